// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a tick-paced shift FSM.
// The baud input is edge-detected in the system clock domain; each rising edge is one bit time.
module uart_tx_buffered #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n_sync,
    input  logic                         i_baud_clk,
    input  logic                         i_wr_en,
    input  logic [7:0]                   i_wr_data,
    input  logic                         i_clr_err,
    output logic                         o_tx,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(FIFO_DEPTH):0]  o_count,
    output logic                         o_busy,
    output logic                         o_overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FullCount = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e         state_q;
    logic [7:0]     shreg_q;
    logic [2:0]     bit_cnt_q;
    logic           tx_q;
    logic           baud_q;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PW:0]    count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           tick, push, pop, drop, full, empty;

    assign tick  = i_baud_clk & ~baud_q;
    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    assign push  = i_wr_en & ~full;
    assign drop  = i_wr_en & full;
    // Uses the pre-cycle count, so a byte written this cycle cannot be popped this cycle.
    assign pop   = tick & ~empty & ((state_q == StIdle) | (state_q == StStop));

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
        overflow_d = drop | (overflow_q & ~i_clr_err);
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n_sync) begin
        if (!i_rst_n_sync) begin
            baud_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            baud_q     <= i_baud_clk;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n_sync) begin
        if (!i_rst_n_sync) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        shreg_q <= mem_q[rd_ptr_q];
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                StStart: begin
                    tx_q      <= shreg_q[0];
                    bit_cnt_q <= '0;
                    state_q   <= StData;
                end
                StData: begin
                    if (bit_cnt_q != 3'd7) begin
                        shreg_q   <= shreg_q >> 1;
                        tx_q      <= shreg_q[1];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end else begin
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    // Back-to-back frames: the next start bit replaces the idle bit.
                    if (pop) begin
                        shreg_q <= mem_q[rd_ptr_q];
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end else begin
                        tx_q    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_tx       = tx_q;
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_count    = count_q;
    assign o_busy     = (state_q != StIdle);
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: tabled single frames plus hand-written corner sequences.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_err = 1'b0;
    logic       tx, full, empty, busy, overflow;
    logic [3:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;  // bit i = expected line level after tick i
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    uart_tx_buffered #(.FIFO_DEPTH(8)) dut (
        .i_clk        (clk),
        .i_rst_n_sync (rst_n),
        .i_baud_clk   (baud),
        .i_wr_en      (wr_en),
        .i_wr_data    (wr_data),
        .i_clr_err    (clr_err),
        .o_tx         (tx),
        .o_full       (full),
        .o_empty      (empty),
        .o_count      (count),
        .o_busy       (busy),
        .o_overflow   (overflow)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick_wr(input logic en, input logic [7:0] d);
        baud = 1'b1; wr_en = en; wr_data = d;
        step();
        baud = 1'b0; wr_en = 1'b0;
        step();
    endtask

    task automatic do_tick();
        do_tick_wr(1'b0, 8'h00);
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic expect_frame(input string nm, input logic [9:0] bits, input logic [3:0] cnt0);
        for (int i = 0; i < 10; i++) begin
            do_tick();
            check($sformatf("%s tx[%0d]", nm, i), 32'(tx), 32'(bits[i]));
            check($sformatf("%s busy[%0d]", nm, i), 32'(busy), 32'd1);
            if (i == 0) check($sformatf("%s count", nm), 32'(count), 32'(cnt0));
        end
    endtask

    task automatic rx_byte(input bit skip_start, input string nm, output logic [7:0] d);
        d = 8'h00;
        for (int i = (skip_start ? 1 : 0); i < 10; i++) begin
            do_tick();
            if (i == 0) check({nm, " start"}, 32'(tx), 32'd0);
            else if (i < 9) d[i-1] = tx;
            else check({nm, " stop"}, 32'(tx), 32'd1);
        end
    endtask

    task automatic idle_tick(input string nm);
        do_tick();
        check({nm, " idle tx"}, 32'(tx), 32'd1);
        check({nm, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] exp_q [8];
        int low_cnt, busy_cnt;

        vecs[0] = '{data: 8'hA5, bits: 10'b1101001010};
        vecs[1] = '{data: 8'h00, bits: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, bits: 10'b1111111110};
        vecs[3] = '{data: 8'h80, bits: 10'b1100000000};
        vecs[4] = '{data: 8'h01, bits: 10'b1000000010};

        // Reset state, baud held high through release
        step(); step();
        check("rst tx", 32'(tx), 32'd1);
        check("rst empty", 32'(empty), 32'd1);
        check("rst full", 32'(full), 32'd0);
        check("rst count", 32'(count), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // No tick until the first rising edge after release
        write_byte(8'h3C);
        for (int i = 0; i < 5; i++) begin
            step();
            check("no-edge busy", 32'(busy), 32'd0);
            check("no-edge tx", 32'(tx), 32'd1);
        end
        check("no-edge count", 32'(count), 32'd1);
        baud = 1'b0;
        step();
        do_tick();
        check("first edge tx", 32'(tx), 32'd0);
        check("first edge busy", 32'(busy), 32'd1);
        rx_byte(1'b1, "3C", got);
        check("3C data", 32'(got), 32'h3C);
        idle_tick("3C");

        // Table of single frames from idle
        for (int v = 0; v < 5; v++) begin
            write_byte(vecs[v].data);
            check($sformatf("vec%0d count", v), 32'(count), 32'd1);
            expect_frame($sformatf("vec%0d", v), vecs[v].bits, 4'd0);
            idle_tick($sformatf("vec%0d", v));
        end

        // Back-to-back frames
        write_byte(8'h11);
        write_byte(8'h22);
        check("b2b count2", 32'(count), 32'd2);
        expect_frame("b2b 11", 10'b1000100010, 4'd1);
        expect_frame("b2b 22", 10'b1001000100, 4'd0);
        idle_tick("b2b");

        // Fill, overflow, clear, set-wins, and drop on a STOP-state pop
        for (int i = 0; i < 8; i++) begin
            write_byte(8'h10 + 8'(i));
        end
        check("fill full", 32'(full), 32'd1);
        check("fill count", 32'(count), 32'd8);
        check("fill no ovf", 32'(overflow), 32'd0);
        write_byte(8'h99);
        check("drop ovf", 32'(overflow), 32'd1);
        check("drop count", 32'(count), 32'd8);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("clr ovf", 32'(overflow), 32'd0);
        wr_en = 1'b1; wr_data = 8'h98; clr_err = 1'b1; step();
        wr_en = 1'b0; clr_err = 1'b0;
        check("set wins", 32'(overflow), 32'd1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("clr2 ovf", 32'(overflow), 32'd0);

        do_tick();
        check("pop0 tx", 32'(tx), 32'd0);
        check("pop0 count", 32'(count), 32'd7);
        write_byte(8'hC3);
        check("refill full", 32'(full), 32'd1);
        rx_byte(1'b1, "q0", got);
        check("q0 data", 32'(got), 32'h10);
        do_tick_wr(1'b1, 8'hEE);
        check("stop-pop drop ovf", 32'(overflow), 32'd1);
        check("stop-pop count", 32'(count), 32'd7);
        check("stop-pop tx", 32'(tx), 32'd0);
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hC3};
        for (int i = 0; i < 8; i++) begin
            rx_byte(i == 0, $sformatf("q%0d", i + 1), got);
            check($sformatf("q%0d data", i + 1), 32'(got), 32'(exp_q[i]));
        end
        idle_tick("queue");
        check("queue empty", 32'(empty), 32'd1);
        clr_err = 1'b1; step(); clr_err = 1'b0;

        // Write to empty FIFO coincident with an idle tick is not popped that tick
        do_tick_wr(1'b1, 8'h5A);
        check("coinc busy", 32'(busy), 32'd0);
        check("coinc tx", 32'(tx), 32'd1);
        check("coinc count", 32'(count), 32'd1);
        rx_byte(1'b0, "5A", got);
        check("5A data", 32'(got), 32'h5A);
        idle_tick("5A");

        // Real divider rate: 868 cycles per bit
        write_byte(8'h00);
        low_cnt = 0;
        busy_cnt = 0;
        for (int k = 0; k < 868 * 12; k++) begin
            baud = ((k % 868) >= 434);
            step();
            if (tx === 1'b0) low_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
        baud = 1'b0;
        step();
        check("div868 low cycles", 32'(low_cnt), 32'd7812);
        check("div868 frame cycles", 32'(busy_cnt), 32'd8680);

        // Reset during d3 of 0xFF with three bytes queued
        write_byte(8'hFF);
        do_tick();
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        check("pre-rst count", 32'(count), 32'd3);
        for (int i = 0; i < 4; i++) do_tick();
        check("pre-rst busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst tx", 32'(tx), 32'd1);
        check("async rst count", 32'(count), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst empty", 32'(empty), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            do_tick();
            check($sformatf("post-rst tx[%0d]", i), 32'(tx), 32'd1);
            check($sformatf("post-rst busy[%0d]", i), 32'(busy), 32'd0);
        end
        check("post-rst count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
